// File: rtl/door_lock_ctrl.sv
// Keypad door lock: collects up to four BCD digits, checks them against a master
// or one-shot temporary password, drives the lock actuator and latches an alarm.
module door_lock_ctrl #(
  parameter int MAX_TRY       = 5,
  parameter int ENTRY_TIMEOUT = 1000,
  parameter int OPEN_TIMEOUT  = 500
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic        CLOSE_SENSOR,
  input  logic        ALERT_OFF,
  input  logic [15:0] PW,
  input  logic [15:0] PW_TEMP,
  input  logic        PW_TEMP_VALID,
  output logic [15:0] DISPLAY,
  output logic        UNLOCK,
  output logic        ALERT,
  output logic        PW_TEMP_CLR,
  output logic [2:0]  WRONG_CNT,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY     = 3'd1,
    S_CHECK     = 3'd2,
    S_OPEN_WAIT = 3'd3,
    S_OPEN_AJAR = 3'd4,
    S_ALARM     = 3'd5
  } state_t;

  localparam int ET_W = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
  localparam int OT_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
  localparam logic [ET_W-1:0] ENTRY_LAST = ET_W'(ENTRY_TIMEOUT - 1);
  localparam logic [OT_W-1:0] OPEN_LAST  = OT_W'(OPEN_TIMEOUT - 1);
  localparam logic [2:0]      MAX_TRY_C  = 3'(MAX_TRY);
  localparam logic [3:0]      KEY_STAR   = 4'd10;
  localparam logic [3:0]      KEY_HASH   = 4'd11;
  localparam logic [2:0]      FULL_CNT   = 3'd4;

  state_t          state_q, state_d;
  logic [15:0]     display_q, display_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      wrong_q, wrong_d;
  logic [ET_W-1:0] etmr_q, etmr_d;
  logic [OT_W-1:0] otmr_q, otmr_d;
  logic            unlock_q, unlock_d;
  logic            alert_q, alert_d;
  logic            clr_q, clr_d;
  logic [2:0]      wrong_inc_s;
  logic            full_s;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  assign wrong_inc_s = wrong_q + 3'd1;
  assign full_s      = (cnt_q == FULL_CNT);

  // Next-state, datapath and registered-output intent
  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    cnt_d     = cnt_q;
    wrong_d   = wrong_q;
    etmr_d    = etmr_q;
    otmr_d    = otmr_q;
    clr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        etmr_d = '0;
        otmr_d = '0;
        if (KEY_VALID && is_digit(KEY_CODE)) begin
          display_d = {12'h000, KEY_CODE};
          cnt_d     = 3'd1;
          state_d   = S_ENTRY;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ENTRY: begin
        if (KEY_VALID && is_digit(KEY_CODE)) begin
          display_d = {display_q[11:0], KEY_CODE};
          cnt_d     = full_s ? FULL_CNT : (cnt_q + 3'd1);
          etmr_d    = '0;
        end else if (KEY_VALID && (KEY_CODE == KEY_STAR)) begin
          etmr_d  = '0;
          state_d = S_CHECK;
        end else if (KEY_VALID && (KEY_CODE == KEY_HASH)) begin
          display_d = 16'h0000;
          cnt_d     = 3'd0;
          etmr_d    = '0;
          state_d   = S_IDLE;
        end else if (etmr_q == ENTRY_LAST) begin
          display_d = 16'h0000;
          cnt_d     = 3'd0;
          etmr_d    = '0;
          state_d   = S_IDLE;
        end else begin
          etmr_d = etmr_q + ET_W'(1);
        end
      end

      // Short entries never match, even if the partial value happens to equal a password
      S_CHECK: begin
        display_d = 16'h0000;
        cnt_d     = 3'd0;
        otmr_d    = '0;
        if (full_s && (display_q == PW)) begin
          wrong_d = 3'd0;
          state_d = S_OPEN_WAIT;
        end else if (full_s && PW_TEMP_VALID && (display_q == PW_TEMP)) begin
          wrong_d = 3'd0;
          clr_d   = 1'b1;
          state_d = S_OPEN_WAIT;
        end else if (wrong_inc_s == MAX_TRY_C) begin
          wrong_d = wrong_inc_s;
          state_d = S_ALARM;
        end else begin
          wrong_d = wrong_inc_s;
          state_d = S_IDLE;
        end
      end

      S_OPEN_WAIT: begin
        if (!CLOSE_SENSOR) begin
          otmr_d  = '0;
          state_d = S_OPEN_AJAR;
        end else if (otmr_q == OPEN_LAST) begin
          otmr_d  = '0;
          state_d = S_IDLE;
        end else begin
          otmr_d = otmr_q + OT_W'(1);
        end
      end

      S_OPEN_AJAR: begin
        if (CLOSE_SENSOR) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OPEN_AJAR;
        end
      end

      S_ALARM: begin
        if (ALERT_OFF) begin
          wrong_d = 3'd0;
          state_d = S_IDLE;
        end else begin
          state_d = S_ALARM;
        end
      end

      default: begin
        display_d = 16'h0000;
        cnt_d     = 3'd0;
        etmr_d    = '0;
        otmr_d    = '0;
        state_d   = S_IDLE;
      end
    endcase

    unlock_d = (state_d == S_OPEN_WAIT) || (state_d == S_OPEN_AJAR);
    alert_d  = (state_d == S_ALARM);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      display_q <= 16'h0000;
      cnt_q     <= 3'd0;
      wrong_q   <= 3'd0;
      etmr_q    <= '0;
      otmr_q    <= '0;
      unlock_q  <= 1'b0;
      alert_q   <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      cnt_q     <= cnt_d;
      wrong_q   <= wrong_d;
      etmr_q    <= etmr_d;
      otmr_q    <= otmr_d;
      unlock_q  <= unlock_d;
      alert_q   <= alert_d;
      clr_q     <= clr_d;
    end
  end

  assign DISPLAY     = display_q;
  assign UNLOCK      = unlock_q;
  assign ALERT       = alert_q;
  assign PW_TEMP_CLR = clr_q;
  assign WRONG_CNT   = wrong_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl: a vector table for the basic entry flows
// plus hand-written sequences for timeouts, alarm handling and async reset.
module tb_door_lock_ctrl;

  logic        CLK;
  logic        RESET;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic        CLOSE_SENSOR;
  logic        ALERT_OFF;
  logic [15:0] PW;
  logic [15:0] PW_TEMP;
  logic        PW_TEMP_VALID;
  logic [15:0] DISPLAY;
  logic        UNLOCK;
  logic        ALERT;
  logic        PW_TEMP_CLR;
  logic [2:0]  WRONG_CNT;
  logic [2:0]  STATE;

  int n_cmp;
  int n_err;

  door_lock_ctrl dut (
    .CLK(CLK), .RESET(RESET), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
    .CLOSE_SENSOR(CLOSE_SENSOR), .ALERT_OFF(ALERT_OFF), .PW(PW), .PW_TEMP(PW_TEMP),
    .PW_TEMP_VALID(PW_TEMP_VALID), .DISPLAY(DISPLAY), .UNLOCK(UNLOCK), .ALERT(ALERT),
    .PW_TEMP_CLR(PW_TEMP_CLR), .WRONG_CNT(WRONG_CNT), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        cs;
    logic        tv;
    logic [2:0]  st;
    logic [15:0] d;
    logic        u;
    logic        c;
    logic [2:0]  w;
  } vec_t;

  vec_t tbl [32];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] st, input logic [15:0] d,
                     input logic u, input logic a, input logic c, input logic [2:0] w);
    logic [24:0] got;
    logic [24:0] want;
    got  = {STATE, DISPLAY, UNLOCK, ALERT, PW_TEMP_CLR, WRONG_CNT};
    want = {st, d, u, a, c, w};
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s: got st=%0d disp=%h unl=%b alr=%b clr=%b wrong=%0d, want st=%0d disp=%h unl=%b alr=%b clr=%b wrong=%0d",
               nm, STATE, DISPLAY, UNLOCK, ALERT, PW_TEMP_CLR, WRONG_CNT, st, d, u, a, c, w);
    end
  endtask

  task automatic press(input logic [3:0] k);
    KEY_VALID = 1'b1;
    KEY_CODE  = k;
    step();
    KEY_VALID = 1'b0;
    KEY_CODE  = 4'd0;
  endtask

  // Four digits, '*', then one more edge so CHECK has been left
  task automatic attempt(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
    press(4'd10);
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET = 1'b1;
    KEY_VALID = 1'b0;
    KEY_CODE = 4'd0;
    CLOSE_SENSOR = 1'b1;
    ALERT_OFF = 1'b0;
    PW = 16'h1234;
    PW_TEMP = 16'h5678;
    PW_TEMP_VALID = 1'b1;

    //            kv    kc     cs    tv    st    disp      u     c     w
    tbl[0]  = '{1'b1, 4'd1,  1'b1, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 4'd2,  1'b1, 1'b1, 3'd1, 16'h0012, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 4'd3,  1'b1, 1'b1, 3'd1, 16'h0123, 1'b0, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 4'd4,  1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 4'd10, 1'b1, 1'b1, 3'd2, 16'h1234, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b0, 3'd0};
    tbl[6]  = '{1'b0, 4'd0,  1'b0, 1'b1, 3'd4, 16'h0000, 1'b1, 1'b0, 3'd0};
    tbl[7]  = '{1'b0, 4'd0,  1'b0, 1'b1, 3'd4, 16'h0000, 1'b1, 1'b0, 3'd0};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{1'b1, 4'd5,  1'b1, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 3'd0};
    tbl[10] = '{1'b1, 4'd6,  1'b1, 1'b1, 3'd1, 16'h0056, 1'b0, 1'b0, 3'd0};
    tbl[11] = '{1'b1, 4'd7,  1'b1, 1'b1, 3'd1, 16'h0567, 1'b0, 1'b0, 3'd0};
    tbl[12] = '{1'b1, 4'd8,  1'b1, 1'b1, 3'd1, 16'h5678, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{1'b1, 4'd10, 1'b1, 1'b1, 3'd2, 16'h5678, 1'b0, 1'b0, 3'd0};
    tbl[14] = '{1'b0, 4'd0,  1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b1, 3'd0};
    tbl[15] = '{1'b1, 4'd3,  1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b0, 3'd0};
    tbl[16] = '{1'b0, 4'd0,  1'b0, 1'b1, 3'd4, 16'h0000, 1'b1, 1'b0, 3'd0};
    tbl[17] = '{1'b0, 4'd0,  1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0};
    tbl[18] = '{1'b1, 4'd7,  1'b1, 1'b1, 3'd1, 16'h0007, 1'b0, 1'b0, 3'd0};
    tbl[19] = '{1'b1, 4'd11, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0};
    tbl[20] = '{1'b1, 4'd10, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0};
    tbl[21] = '{1'b1, 4'd13, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0};
    tbl[22] = '{1'b1, 4'd1,  1'b1, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 3'd0};
    tbl[23] = '{1'b1, 4'd10, 1'b1, 1'b1, 3'd2, 16'h0001, 1'b0, 1'b0, 3'd0};
    tbl[24] = '{1'b0, 4'd0,  1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd1};
    tbl[25] = '{1'b1, 4'd6,  1'b1, 1'b1, 3'd1, 16'h0006, 1'b0, 1'b0, 3'd1};
    tbl[26] = '{1'b1, 4'd1,  1'b1, 1'b1, 3'd1, 16'h0061, 1'b0, 1'b0, 3'd1};
    tbl[27] = '{1'b1, 4'd2,  1'b1, 1'b1, 3'd1, 16'h0612, 1'b0, 1'b0, 3'd1};
    tbl[28] = '{1'b1, 4'd3,  1'b1, 1'b1, 3'd1, 16'h6123, 1'b0, 1'b0, 3'd1};
    tbl[29] = '{1'b1, 4'd4,  1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, 1'b0, 3'd1};
    tbl[30] = '{1'b1, 4'd10, 1'b1, 1'b1, 3'd2, 16'h1234, 1'b0, 1'b0, 3'd1};
    tbl[31] = '{1'b0, 4'd0,  1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b0, 3'd0};

    #12;
    chk("reset_state", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    RESET = 1'b0;

    for (int i = 0; i < 32; i++) begin
      KEY_VALID     = tbl[i].kv;
      KEY_CODE      = tbl[i].kc;
      CLOSE_SENSOR  = tbl[i].cs;
      PW_TEMP_VALID = tbl[i].tv;
      step();
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].d, tbl[i].u, 1'b0, tbl[i].c, tbl[i].w);
    end
    KEY_VALID = 1'b0;
    KEY_CODE  = 4'd0;

    // Door never opened: relock exactly after the open timeout
    repeat (499) step();
    chk("open_wait_hold", 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
    step();
    chk("open_timeout", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);

    // Partial entry discarded after the entry timeout
    press(4'd1);
    press(4'd2);
    repeat (999) step();
    chk("entry_hold", 3'd1, 16'h0012, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk("entry_timeout", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    press(4'd1);
    press(4'd2);
    press(4'd10);
    step();
    chk("short_after_to", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd1);

    attempt(16'h1234);
    chk("clear_by_pw", 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
    CLOSE_SENSOR = 1'b0;
    step();
    CLOSE_SENSOR = 1'b1;
    step();

    // Five wrong attempts lead to the alarm
    for (int n = 1; n <= 4; n++) begin
      attempt(16'h9999);
      chk($sformatf("wrong%0d", n), 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'(n));
      if (n == 2) begin
        ALERT_OFF = 1'b1;
        step();
        ALERT_OFF = 1'b0;
        chk("alert_off_idle", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2);
      end
    end
    attempt(16'h9999);
    chk("alarm_entry", 3'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd5);
    press(4'd3);
    chk("alarm_key", 3'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd5);
    ALERT_OFF = 1'b1;
    step();
    ALERT_OFF = 1'b0;
    chk("alarm_clear", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);

    // Master password wins over an equal temporary one: no consume pulse
    PW = 16'h4321;
    PW_TEMP = 16'h4321;
    PW_TEMP_VALID = 1'b1;
    attempt(16'h4321);
    chk("pw_priority", 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
    CLOSE_SENSOR = 1'b0;
    step();
    CLOSE_SENSOR = 1'b1;
    step();
    PW = 16'h1234;
    PW_TEMP = 16'h5678;
    PW_TEMP_VALID = 1'b0;
    attempt(16'h5678);
    chk("temp_unarmed", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd1);

    // Async reset mid-entry, then immediate key acceptance
    press(4'd1);
    press(4'd2);
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_mid_entry", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    #2;
    RESET = 1'b0;
    press(4'd7);
    chk("first_key", 3'd1, 16'h0007, 1'b0, 1'b0, 1'b0, 3'd0);

    // Async reset while the door is ajar
    attempt(16'h1234);
    CLOSE_SENSOR = 1'b0;
    step();
    chk("ajar", 3'd4, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_ajar", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    #2;
    RESET = 1'b0;
    CLOSE_SENSOR = 1'b1;
    step();
    chk("post_rst", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/door_lock_ctrl.md
DOOR_LOCK_CTRL -- requirements
Module: door_lock_ctrl

Parameters
REQ-001 SHALL provide MAX_TRY, default 5: consecutive wrong attempts that trigger ALARM.
REQ-002 SHALL provide ENTRY_TIMEOUT, default 1000: idle cycles after the last key before partial entry is discarded.
REQ-003 SHALL provide OPEN_TIMEOUT, default 500: cycles in OPEN_WAIT without the door opening before relock.

Interface
REQ-004 SHALL have ports as follows.
- CLK  in  1: single clock; all state on rising edge.
- RESET  in  1: asynchronous, active-high reset.
- KEY_VALID  in  1: one-cycle strobe; KEY_CODE is valid this cycle.
- KEY_CODE  in  4: 0-9 digit, 10 '*' (enter), 11 '#' (clear), 12-15 ignored.
- CLOSE_SENSOR  in  1: 1 = door closed.
- ALERT_OFF  in  1: level; clears alarm.
- PW  in  16: master password, 4 BCD nibbles.
- PW_TEMP  in  16: temporary password, 4 BCD nibbles.
- PW_TEMP_VALID  in  1: PW_TEMP is armed.
- DISPLAY  out  16: digits entered so far, newest in [3:0].
- UNLOCK  out  1: lock actuator open.
- ALERT  out  1: alarm active.
- PW_TEMP_CLR  out  1: one-cycle pulse consuming PW_TEMP.
- WRONG_CNT  out  3: consecutive wrong attempts.
- STATE  out  3: current FSM state.

Function
REQ-005 SHALL implement states IDLE=0, ENTRY=1, CHECK=2, OPEN_WAIT=3, OPEN_AJAR=4, ALARM=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-006 IDLE: a digit key SHALL load DISPLAY={12'h000,digit}, set digit count=1, and go to ENTRY; '*', '#' and codes 12-15 SHALL be ignored.
REQ-007 ENTRY: a digit key SHALL set DISPLAY={DISPLAY[11:0],digit} and increment digit count, saturating at 4; with more than 4 digits, the oldest digit is lost.
REQ-008 ENTRY: '#' SHALL clear DISPLAY and digit count and return to IDLE, with no attempt counted.
REQ-009 ENTRY: '*' SHALL go to CHECK on the next edge; a '*' with digit count below 4 SHALL be forced to mismatch in CHECK.
REQ-010 ENTRY: the inactivity counter SHALL reset on every accepted key; reaching ENTRY_TIMEOUT SHALL clear DISPLAY and go to IDLE, with no attempt counted.
REQ-011 CHECK SHALL last exactly one cycle, and key strobes in CHECK SHALL be dropped.
- DISPLAY==PW goes to OPEN_WAIT and clears WRONG_CNT.
- Otherwise PW_TEMP_VALID && DISPLAY==PW_TEMP goes to OPEN_WAIT, clears WRONG_CNT and pulses PW_TEMP_CLR for one cycle.
- Otherwise WRONG_CNT increments; if the new value equals MAX_TRY, go to ALARM, else go to IDLE.
REQ-012 PW SHALL take priority when PW and PW_TEMP both match; in that case PW_TEMP_CLR SHALL NOT pulse.
REQ-013 DISPLAY and digit count SHALL be cleared on every exit from CHECK.
REQ-014 UNLOCK SHALL be 1 exactly in OPEN_WAIT and OPEN_AJAR, asserted the cycle after CHECK.
REQ-015 OPEN_WAIT: CLOSE_SENSOR==0 SHALL go to OPEN_AJAR; otherwise, after OPEN_TIMEOUT cycles, go to IDLE (relock).
REQ-016 OPEN_AJAR: CLOSE_SENSOR==1 SHALL go to IDLE; there is no timeout.
REQ-017 ALARM: ALERT SHALL be 1 and keys SHALL be ignored; ALERT_OFF==1 SHALL clear ALERT and WRONG_CNT and go to IDLE.
REQ-018 ALERT_OFF outside ALARM SHALL have no effect, and keys in OPEN_WAIT, OPEN_AJAR and ALARM SHALL be ignored.
REQ-019 WRONG_CNT SHALL persist across IDLE/ENTRY cycles and SHALL clear only on a correct entry, alarm clear, or RESET.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 RESET SHALL act immediately and asynchronously, in any state, including mid-entry and during UNLOCK.
- STATE=IDLE, DISPLAY=0, UNLOCK=0, ALERT=0, PW_TEMP_CLR=0, WRONG_CNT=0.
- All counters cleared.
REQ-022 After RESET deasserts, the first key SHALL be accepted on the next rising edge.

Verification
REQ-023 PW=16'h1234; keys 1,2,3,4,'*' -> CHECK one cycle later, then UNLOCK=1; CLOSE_SENSOR 1->0->1 -> IDLE with UNLOCK=0.
REQ-024 PW=16'h1234, PW_TEMP=16'h5678, PW_TEMP_VALID=1; enter 5678* -> PW_TEMP_CLR high exactly one cycle, UNLOCK=1, WRONG_CNT=0.
REQ-025 Five wrong entries of 9999* -> WRONG_CNT 1..4, then ALERT=1, STATE=5; a key in ALARM leaves DISPLAY at 0; ALERT_OFF=1 -> ALERT=0, WRONG_CNT=0, IDLE.
REQ-026 Enter 1,2 then wait ENTRY_TIMEOUT cycles -> DISPLAY=0, IDLE, WRONG_CNT unchanged; enter 1,2,'*' -> WRONG_CNT+1.
REQ-027 Enter 6,1,2,3,4,'*' with PW=16'h1234 -> DISPLAY=16'h1234 before '*', then unlock; after unlock, hold CLOSE_SENSOR=1 for OPEN_TIMEOUT cycles -> relock to IDLE.
REQ-028 Assert RESET asynchronously mid-entry and again in OPEN_AJAR -> all outputs reach reset values before the next CLK edge.
